// File: rtl/arith_multdiv_pkg.sv
// Shared types for the iterative HI/LO multiply/divide unit: clock/reset
// bundle, operation and signedness selects, and the FSM state encoding.
package arith_multdiv_pkg;

  // Clock and active-low reset travel together as one control bundle.
  typedef struct packed {
    logic clock;
    logic reset;
  } Util_Control_T;

  typedef enum logic {
    Arith_MultDiv_Mult = 1'b0,
    Arith_MultDiv_Div  = 1'b1
  } Arith_MultDiv_T;

  typedef enum logic {
    Arith_SignedUnsigned_Signed   = 1'b0,
    Arith_SignedUnsigned_Unsigned = 1'b1
  } Arith_SignedUnsigned_T;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } Arith_MultDiv_State_T;

  function automatic logic Util_Control_clock(input Util_Control_T c);
    return c.clock;
  endfunction

  function automatic logic Util_Control_reset(input Util_Control_T c);
    return c.reset;
  endfunction

endpackage

// File: rtl/arith_multdiv_cond_negate.sv
// Conditional two's-complement negate: out = neg ? -in : in.
// Used for operand absolute values at load and for sign fixes of results.
module arith_cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);

  // Invert-and-increment when negation is requested.
  always_comb begin
    out_o = in_i;
    if (neg_i) out_o = ~in_i + {{(W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/arith_multdiv.sv
// Iterative multiply/divide for the HI/LO path. One operand bit per cycle,
// W+1 edges from accept to done. Optional divider is built only when the
// macro ARITH_MULTDIV_DIV_EN is defined; otherwise Div requests are ignored.
module arith_multdiv
  import arith_multdiv_pkg::*;
#(
  parameter int W = 32
) (
  input  Util_Control_T         ctrl,
  input  logic                  start,
  input  Arith_MultDiv_T        op,
  input  Arith_SignedUnsigned_T sign,
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  output logic                  busy,
  output logic                  done,
  output logic [W-1:0]          hi,
  output logic [W-1:0]          lo,
  output logic                  div_zero
);

  localparam int              CW       = $clog2(W);
  localparam logic [CW-1:0]   CNT_LAST = CW'(W - 1);

  logic clk;
  logic rst_n;
  assign clk   = Util_Control_clock(ctrl);
  assign rst_n = Util_Control_reset(ctrl);

  Arith_MultDiv_State_T state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*W-1:0]       acc_q, acc_d;     // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]         opnd_q, opnd_d;   // mult: |multiplicand|; div: |divisor|
  logic                 negq_q, negq_d;
  logic [W-1:0]         hi_q, hi_d;
  logic [W-1:0]         lo_q, lo_d;
  logic                 done_q, done_d;

  // Operand magnitudes, only taken when the signed select is active.
  logic         is_signed;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] a_abs;
  logic [W-1:0] b_abs;
  assign is_signed = (sign == Arith_SignedUnsigned_Signed);
  assign a_neg     = is_signed & a[W-1];
  assign b_neg     = is_signed & b[W-1];

  arith_cond_negate #(.W(W)) u_abs_a (.in_i(a), .neg_i(a_neg), .out_o(a_abs));
  arith_cond_negate #(.W(W)) u_abs_b (.in_i(b), .neg_i(b_neg), .out_o(b_abs));

  // Shift-add step: add multiplicand when the current multiplier LSB is set.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_step;
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
  assign mul_step = {mul_sum, acc_q[W-1:1]};

  // Sign fix of the full product.
  logic [2*W-1:0] prod_fix;
  arith_cond_negate #(.W(2*W)) u_fix_prod (.in_i(acc_q), .neg_i(negq_q), .out_o(prod_fix));

  logic accept;

`ifdef ARITH_MULTDIV_DIV_EN
  Arith_MultDiv_T op_q, op_d;
  logic           negr_q, negr_d;
  logic [W-1:0]   araw_q, araw_d;   // raw dividend, reported in HI on divide by zero
  logic           dz_q, dz_d;

  // Restoring step: the remainder stays below the divisor, so only the
  // shifted trial value needs the extra bit.
  logic [W:0]     rem_shift;
  logic [W+1:0]   div_diff;
  logic [2*W-1:0] div_step;
  logic           div_unused;
  assign rem_shift  = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff   = {1'b0, rem_shift} - {2'b00, opnd_q};
  assign div_unused = div_diff[W];
  assign div_step   = div_diff[W+1] ? {rem_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                    : {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};

  logic [W-1:0] quo_fix;
  logic [W-1:0] rem_fix;
  arith_cond_negate #(.W(W)) u_fix_quo (.in_i(acc_q[W-1:0]),   .neg_i(negq_q), .out_o(quo_fix));
  arith_cond_negate #(.W(W)) u_fix_rem (.in_i(acc_q[2*W-1:W]), .neg_i(negr_q), .out_o(rem_fix));

  assign accept   = start && (state_q == ST_IDLE);
  assign div_zero = dz_q;
`else
  assign accept   = start && (state_q == ST_IDLE) && (op == Arith_MultDiv_Mult);
  assign div_zero = 1'b0;
`endif

  // Next-state and datapath updates for IDLE/RUN/FIX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    negq_d  = negq_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef ARITH_MULTDIV_DIV_EN
    op_d    = op_q;
    negr_d  = negr_q;
    araw_d  = araw_q;
    dz_d    = dz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          cnt_d   = CNT_LAST;
          negq_d  = a_neg ^ b_neg;
          acc_d   = {{W{1'b0}}, b_abs};
          opnd_d  = a_abs;
`ifdef ARITH_MULTDIV_DIV_EN
          op_d    = op;
          negr_d  = a_neg;
          araw_d  = a;
          if (op == Arith_MultDiv_Div) begin
            acc_d  = {{W{1'b0}}, a_abs};
            opnd_d = b_abs;
          end
`endif
        end
      end
      ST_RUN: begin
        acc_d = mul_step;
`ifdef ARITH_MULTDIV_DIV_EN
        if (op_q == Arith_MultDiv_Div) acc_d = div_step;
`endif
        if (cnt_q == {CW{1'b0}}) state_d = ST_FIX;
        else                     cnt_d   = cnt_q - CW'(1);
      end
      ST_FIX: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        {hi_d, lo_d} = prod_fix;
`ifdef ARITH_MULTDIV_DIV_EN
        dz_d = 1'b0;
        if (op_q == Arith_MultDiv_Div) begin
          if (opnd_q == {W{1'b0}}) begin
            lo_d = {W{1'b1}};
            hi_d = araw_q;
            dz_d = 1'b1;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      acc_q   <= {(2*W){1'b0}};
      opnd_q  <= {W{1'b0}};
      negq_q  <= 1'b0;
      hi_q    <= {W{1'b0}};
      lo_q    <= {W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      negq_q  <= negq_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

`ifdef ARITH_MULTDIV_DIV_EN
  // Divide-only registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= Arith_MultDiv_Mult;
      negr_q <= 1'b0;
      araw_q <= {W{1'b0}};
      dz_q   <= 1'b0;
    end else begin
      op_q   <= op_d;
      negr_q <= negr_d;
      araw_q <= araw_d;
      dz_q   <= dz_d;
    end
  end
`endif

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/arith_multdiv.md
# arith_multdiv

Iterative multi-cycle multiply/divide unit for the MIPS HI/LO path, one stage downstream of operand extension in the execute stage. Accepts two W-bit operands with a signed/unsigned select and produces a 2W-bit product or a quotient/remainder pair in HI/LO. It uses a start/busy/done handshake so the pipeline can stall on MFHI/MFLO while an operation is in flight.

## Interface
- W, 32, operand and HI/LO width; W ≥ 4.
- ctrl  input  Util_Control_T  `Util_Control_clock(ctrl)` is the single clock; `Util_Control_reset(ctrl)` is the reset, asynchronous and active-low.
- start  input  1  request an operation; sampled on the rising edge.
- op  input  Arith_MultDiv_T  `Arith_MultDiv_Mult` or `Arith_MultDiv_Div`.
- sign  input  Arith_SignedUnsigned_T  `Arith_SignedUnsigned_Signed` or `_Unsigned`.
- a  input  W  multiplicand or dividend.
- b  input  W  multiplier or divisor.
- busy  output  1  operation in flight; start is ignored while high.
- done  output  1  one-cycle pulse; hi/lo are valid from this cycle on.
- hi  output  W  product upper half, or remainder.
- lo  output  W  product lower half, or quotient.
- div_zero  output  1  last completed op was a divide with b == 0; held until the next done.

## Operation
- States: IDLE, RUN, FIX.
- IDLE + start: latch op and sign. Latch |a| and |b|; absolute values apply only when signed, otherwise raw values. Record neg_q = a[W-1]^b[W-1] and neg_r = a[W-1] (signed only; both 0 when unsigned). Set counter to W-1 and go to RUN.
- RUN multiply: shift-add on a 2W accumulator, one multiplier bit per cycle, LSB first.
- RUN divide: restoring division, one quotient bit per cycle, MSB first. The W+1-bit partial remainder never overflows.
- RUN: when counter == 0, go to FIX. Otherwise decrement the counter.
- FIX, multiply: {hi,lo} = neg_q ? −acc : acc.
- FIX, divide: lo = neg_q ? −q : q; hi = neg_r ? −r : r.
- FIX, divide with b == 0: lo = {W{1}}, hi = a (raw), div_zero = 1. This applies in both signed and unsigned modes.
- FIX, otherwise: div_zero = 0.
- FIX always ends by pulsing done and returning to IDLE.
- Signed −2^(W−1) / −1: lo = 0x8000_0000, hi = 0, no flag. All results are modulo 2^W with no saturation.
- hi/lo/div_zero change only on the FIX edge. They hold between operations.
- Operands a/b/op/sign need only be valid in the start cycle.

## Timing
- Reset (async, asserted low): state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, div_zero = 0, counter = 0. Reset takes effect immediately, including mid-RUN or mid-FIX; the in-flight op is discarded.
- Let edge k be the edge that accepts start. Then:
  - busy = 1 after edge k through edge k+W.
  - FIX occupies the cycle after edge k+W.
  - Edge k+W+1 writes hi/lo and sets done = 1, busy = 0 for one cycle.
  - Latency is W+1 edges; throughput is one op per W+2 cycles.
- start in the done cycle is accepted (state is IDLE). This gives back-to-back operation with no gap cycle.
- start while busy is dropped with no effect. It is not queued.

## Configuration
- `ARITH_MULTDIV_DIV_EN`, defined: divide datapath, restoring subtractor and div_zero logic are built as described.
- `ARITH_MULTDIV_DIV_EN`, undefined:
  - No divide hardware; div_zero is tied 0.
  - start with op = Div is ignored: not accepted, busy stays 0, no done, hi/lo unchanged.
  - Multiply behaviour and timing are identical in both builds.

## Structure
- The shared header/package Arith/MultDiv.v defines:
  - `Arith_MultDiv_T`, `Arith_MultDiv_Mult`, `Arith_MultDiv_Div`.
  - The FSM state encoding and its constants.
- `Arith_SignedUnsigned_T` is reused from Arith/SignedUnsigned.v.
- One sub-module, arith_cond_negate: combinational, parameter W, `out = neg ? −in : in`. It is used for the operand absolute values at load and for the result fixes in FIX.
- Counter width is $clog2(W).

## Test plan
- Reset then idle (W = 32): busy = 0, done = 0, hi = lo = 0. Assert reset mid-RUN: all outputs are 0 immediately, and the next start works.
- Unsigned mult 0xFFFFFFFF × 0xFFFFFFFF: done exactly 33 edges after accept, hi = 0xFFFFFFFE, lo = 0x00000001.
- Signed mult −3 × 5: hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. Unsigned mult of the same bits: hi = 0x00000004, lo = 0xFFFFFFF1.
- Divides:
  - Signed −7 / 2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - Unsigned 100 / 7: lo = 14, hi = 2.
  - Signed 0x80000000 / −1: lo = 0x80000000, hi = 0.
- Divide by zero, 10 / 0: lo = 0xFFFFFFFF, hi = 0x0000000A, div_zero = 1. A following 6 × 7 gives lo = 42 and clears div_zero.
- Handshake:
  - start pulses during busy are ignored: result equals the first op, done pulses once.
  - start in the done cycle is accepted: second done comes 33 edges later.
  - Without `ARITH_MULTDIV_DIV_EN`, a Div start never raises busy.
